// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick-enable scheduler.
package tick_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_sched_chan.sv
// One scheduler channel: IDLE/RUN FSM, base-tick down-counter and registered enable pulse.
// One-shot support is built only when TICK_SCHED_ONESHOT_EN is defined.
module tick_sched_chan
  import tick_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                base_tick_i,
  input  logic                load_i,
  input  logic                stop_i,
  input  logic                mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_en_o,
  output logic                busy_o
);

  chan_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                tick_q, tick_d;
`ifdef TICK_SCHED_ONESHOT_EN
  logic                mode_q, mode_d;
`else
  logic                unused_mode;
  assign unused_mode = mode_i;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    tick_d   = 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
    mode_d   = mode_q;
`endif
    // Config loads never coincide with base_tick, so load/stop take priority safely.
    if (load_i) begin
      state_d  = ST_RUN;
      count_d  = period_i - PERIOD_W'(1);
      period_d = period_i;
`ifdef TICK_SCHED_ONESHOT_EN
      mode_d   = mode_i;
`endif
    end else if (stop_i) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN && base_tick_i) begin
      if (count_q != '0) begin
        count_d = count_q - PERIOD_W'(1);
      end else begin
        tick_d  = 1'b1;
        count_d = period_q - PERIOD_W'(1);
`ifdef TICK_SCHED_ONESHOT_EN
        if (mode_q == MODE_ONESHOT) state_d = ST_IDLE;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
      mode_q   <= MODE_PERIODIC;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      tick_q   <= tick_d;
`ifdef TICK_SCHED_ONESHOT_EN
      mode_q   <= mode_d;
`endif
    end
  end

  assign tick_en_o = tick_q;
  assign busy_o    = (state_q == ST_RUN);

endmodule

// File: rtl/tick_enable_sched.sv
// Multi-channel clock-enable scheduler: shared prescaler, config decode and per-channel tickers.
// Define TICK_SCHED_ONESHOT_EN to honour cfg_mode (one-shot channels).
module tick_enable_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PRESCALE = 25_000,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned CH_W     = ch_width(NUM_CH)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_start,
  input  logic                cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                cfg_err,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   tick_en,
  output logic [NUM_CH-1:0]   busy
);

  localparam int unsigned PsW = $clog2(PRESCALE);

  logic [PsW-1:0] presc_q, presc_d;
  logic           presc_wrap;
  logic           base_tick_q;
  logic           cfg_err_q, cfg_err_d;
  logic           accept;
  logic           period_zero;

  assign presc_wrap = (presc_q == PsW'(PRESCALE - 1));
  assign presc_d    = presc_wrap ? '0 : presc_q + PsW'(1);

  // Blocking config during the base-tick cycle keeps loads and count updates apart.
  assign cfg_ready   = ~base_tick_q;
  assign accept      = cfg_valid & cfg_ready;
  assign period_zero = (cfg_period == '0);
  assign cfg_err_d   = accept & cfg_start & period_zero;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q     <= '0;
      base_tick_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      base_tick_q <= presc_wrap;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign base_tick = base_tick_q;
  assign cfg_err   = cfg_err_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    logic sel;
    assign sel = accept & (cfg_ch == CH_W'(ch));

    tick_sched_chan #(
      .PERIOD_W (PERIOD_W)
    ) u_chan (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .base_tick_i (base_tick_q),
      .load_i      (sel & cfg_start & ~period_zero),
      .stop_i      (sel & ~cfg_start),
      .mode_i      (cfg_mode),
      .period_i    (cfg_period),
      .tick_en_o   (tick_en[ch]),
      .busy_o      (busy[ch])
    );
  end

endmodule

// File: tb/tb_tick_enable_sched.sv
// Self-checking bench for tick_enable_sched: expected tick cycles queued at config time,
// popped and compared as tick_en pulses appear.
module tb_tick_enable_sched;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 4;
  localparam int PERIOD_W = 16;
  localparam int CH_W     = 2;

  logic                Clk = 1'b0;
  logic                Reset_n = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic                cfg_start = 1'b0;
  logic                cfg_mode = 1'b0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                cfg_err;
  logic                base_tick;
  logic [NUM_CH-1:0]   tick_en;
  logic [NUM_CH-1:0]   busy;

  tick_enable_sched #(
    .NUM_CH   (NUM_CH),
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_start  (cfg_start),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_err    (cfg_err),
    .base_tick  (base_tick),
    .tick_en    (tick_en),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int ch;
    int at;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   run[NUM_CH];
  bit   oneshot[NUM_CH];
  int   per[NUM_CH];
  bit   err_exp;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bt_at(int n);
    return (n != 0) && (n % PRESCALE == 0);
  endfunction

  function automatic int ceil_bt(int n);
    return ((n + PRESCALE - 1) / PRESCALE) * PRESCALE;
  endfunction

  function automatic logic [NUM_CH-1:0] busy_exp();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = run[i];
    return v;
  endfunction

  function automatic int find_idx(int ch);
    int j;
    j = -1;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].ch == ch && (j < 0 || sb[i].at < sb[j].at)) j = i;
    return j;
  endfunction

  task automatic drop_ch(int ch);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].ch == ch) sb.delete(i);
  endtask

  task automatic push_exp(int ch, int at);
    exp_t e;
    e.ch = ch;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    bit bt_e;
    int j;
    exp_t e;
    bt_e = bt_at(cyc);
    check_eq("base_tick", base_tick, bt_e);
    check_eq("cfg_ready", cfg_ready, !bt_e);
    check_eq("cfg_err", cfg_err, err_exp);
    check_eq("busy", busy, busy_exp());
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (tick_en[ch]) begin
        j = find_idx(ch);
        if (j < 0) begin
          check_eq($sformatf("tick_spurious%0d", ch), tick_en[ch], 1'b0);
        end else begin
          e = sb[j];
          check_eq($sformatf("tick_time%0d", ch), cyc, e.at);
          sb.delete(j);
          if (!oneshot[ch]) push_exp(ch, e.at + PRESCALE * per[ch]);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at < cyc) begin
        check_eq($sformatf("tick_missing%0d", sb[i].ch), cyc, sb[i].at);
        sb.delete(i);
      end
  endtask

  // Advance one clock, update the model at the edge, then check at the falling edge.
  task automatic cycle();
    bit acc;
    int ch;
    acc = cfg_valid && !bt_at(cyc);
    ch  = int'(cfg_ch);
    @(posedge Clk);
    cyc++;
    err_exp = 1'b0;
    foreach (sb[i]) if (sb[i].at == cyc && oneshot[sb[i].ch]) run[sb[i].ch] = 1'b0;
    if (acc) begin
      if (cfg_start && cfg_period == 0) begin
        err_exp = 1'b1;
      end else if (cfg_start) begin
        drop_ch(ch);
        run[ch] = 1'b1;
        per[ch] = int'(cfg_period);
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot[ch] = cfg_mode;
`else
        oneshot[ch] = 1'b0;
`endif
        push_exp(ch, ceil_bt(cyc) + PRESCALE * (per[ch] - 1) + 1);
      end else begin
        drop_ch(ch);
        run[ch] = 1'b0;
      end
    end
    @(negedge Clk);
    check_cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(int ch, bit start, bit mode, int period);
    bit will;
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_start  = start;
    cfg_mode   = mode;
    cfg_period = PERIOD_W'(period);
    for (int k = 0; k < 4; k++) begin
      will = !bt_at(cyc);
      cycle();
      if (will) break;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_base_tick", base_tick, 1'b0);
    check_eq("rst_tick_en", tick_en, '0);
    check_eq("rst_busy", busy, '0);
    check_eq("rst_cfg_err", cfg_err, 1'b0);
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      run[i]     = 1'b0;
      oneshot[i] = 1'b0;
      per[i]     = 0;
    end
    err_exp = 1'b0;
    cyc     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    vectors     = 0;
    miscompares = 0;
    clear_model();
    repeat (3) @(negedge Clk);
    check_reset_outputs();
    Reset_n = 1'b1;
    check_cycle();

    idle(40);

    send(0, 1'b1, 1'b0, 3);
    idle(40);

    send(1, 1'b1, 1'b1, 2);
    idle(30);

    send(2, 1'b1, 1'b0, 0);
    idle(10);

    // Restart ch0 in the base-tick interval just before its pending expiry.
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (find_idx(0) >= 0 && sb[find_idx(0)].at == cyc + 4) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (!found) check_eq("restart_window", cyc, cyc + 4);
    send(0, 1'b1, 1'b0, 5);
    idle(50);

    // Present a request during a base-tick cycle; it must land one cycle later.
    for (int k = 0; k < 8 && !bt_at(cyc); k++) cycle();
    send(3, 1'b1, 1'b0, 1);
    idle(20);

    send(3, 1'b0, 1'b0, 1);
    send(3, 1'b0, 1'b0, 1);
    send(3, 1'b1, 1'b0, 2);
    idle(10);

    Reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge Clk);
    clear_model();
    Reset_n = 1'b1;
    check_cycle();
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
